fmul_round: RTL and testbench
=============================

# fmul_round

Post-multiply normalize/round stage of the single-precision FP multiplier. It consumes the 64-bit integer mantissa product from the integer multiplier, together with the sign, the pre-computed biased exponent sum and special-case flags from the operand unpack logic. It normalizes, rounds to nearest-even, applies overflow/underflow handling, and packs an IEEE-754 binary32 result. It is a 2-stage valid/ready pipeline that can stall.

## Interface
- No parameters; widths are fixed to binary32.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid product/operand set.
- in_ready  out  1  stage can accept this cycle.
- prod  in  64  unsigned product of two 24-bit significands (hidden bit included). Only [47:0] are meaningful; [63:48] are ignored.
- sign  in  1  result sign (sign_a ^ sign_b).
- exp_sum  in  10  two's-complement value ea+eb-127 (range -125..381).
- is_nan, is_inf, is_zero  in  1 each  special-case class, already resolved upstream (inf*0 arrives as is_nan). Priority: nan > inf > zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- result  out  32  packed binary32.
- overflow, underflow, inexact  out  1 each  status flags, qualified by out_valid.

## Operation
- Stage 1 (normalize) is registered on accept.
  - If prod[47]=1: mant=prod[46:24], guard=prod[23], sticky=|prod[22:0], exp=exp_sum+1.
  - Else: mant=prod[45:23], guard=prod[22], sticky=|prod[21:0], exp=exp_sum.
  - Exp arithmetic is 10-bit signed; no wrap is possible in range.
- Stage 2 (round/pack).
  - inc = guard & (sticky | mant[0]).
  - mant_r = mant + inc. If mant was 0x7FFFFF and inc=1, mant_r=0 and exp+1.
  - inexact_raw = guard | sticky.
- Classification, checked in this order:
  - is_nan: result 0x7FC00000, all flags 0.
  - is_inf: result {sign,8'hFF,23'd0}, flags 0.
  - is_zero: result {sign,31'd0}, flags 0.
  - exp ≥ 255 after rounding: result {sign,8'hFF,0}, overflow=1, inexact=1.
  - exp ≤ 0 (before rounding): flush to zero, result {sign,31'd0}, underflow=1, inexact=1. There is no denormal output.
  - Otherwise: result {sign,exp[7:0],mant_r}, inexact=inexact_raw.
- Handshake:
  - en2 = !s2_valid | out_ready.
  - en1 = !s1_valid | en2.
  - in_ready = en1 & reset.
  - Transfers occur on valid & ready at the rising edge.
- While out_valid & !out_ready, result and all flags stay stable and stage 1 holds if it is full.
- A simultaneous input accept and output drain in one cycle sustains full throughput (1 result/cycle).

## Timing
- Latency: 2 cycles from input accept to out_valid, with no stall.
- Throughput: 1 result per cycle.
- Capacity: 2 operations in flight; in_ready drops only when both stages are full and out_ready=0.
- in_ready is combinational from out_ready (one AND/OR level). No other combinational input-to-output paths exist.
- Reset (asynchronous, active-low):
  - s1_valid=0, s2_valid=0, out_valid=0, result=0, all flags=0.
  - in_ready=0 while reset is low and 1 from the first cycle after release.
  - Reset mid-operation discards all in-flight data, with no partial output.
- Data registers may be loaded only on their enable; valid bits alone determine output qualification.

## Test plan
- 1.5×1.5: prod=0x0000_9000_0000_0000, exp_sum=127, sign=0 → after 2 cycles result=0x40100000, flags 0.
- 1.0×1.0: prod=0x0000_4000_0000_0000, exp_sum=127 → result=0x3F800000, inexact=0.
- RNE tie, (1+2^-23)×1.5: prod=0x0000_6000_00C0_0000, exp_sum=127 → result=0x3FC00002, inexact=1.
- Overflow: prod=0x0000_8000_0000_0000, exp_sum=254, sign=1 → result=0xFF800000, overflow=1, inexact=1.
- Underflow: prod=0x0000_4000_0000_0000, exp_sum=0 → result=0x00000000, underflow=1, inexact=1.
- Back-to-back with backpressure: 4 operations issued on consecutive cycles, out_ready=0 for 3 cycles starting when the first result is valid → in_ready=0 once 2 operations are held, result stable, all 4 results emerge in order with no loss or duplication.
- Reset asserted while 2 operations are in flight → out_valid=0 immediately; after release, the first new operation appears 2 cycles after its accept.

Source files
------------

// File: rtl/fmul_round.sv
// rtl/fmul_round.sv - binary32 multiplier normalize/round/pack stage, 2-stage valid/ready pipeline
module fmul_round (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] prod,
    input  logic        sign,
    input  logic [9:0]  exp_sum,
    input  logic        is_nan,
    input  logic        is_inf,
    input  logic        is_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    // Stage 1 state: normalized mantissa, round bits, exponent and class
    logic        r_s1_valid;
    logic [22:0] r_s1_mant;
    logic        r_s1_guard;
    logic        r_s1_sticky;
    logic [9:0]  r_s1_exp;
    logic        r_s1_sign;
    logic        r_s1_nan;
    logic        r_s1_inf;
    logic        r_s1_zero;

    // Stage 2 state: packed result and flags as presented downstream
    logic        r_s2_valid;
    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_inexact;

    logic        w_en1;
    logic        w_en2;

    logic        w_hi;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic [9:0]  w_exp;

    logic        w_inc;
    logic [23:0] w_mant_sum;
    logic [22:0] w_mant_r;
    logic [9:0]  w_exp_r;
    logic [31:0] w_result;
    logic        w_overflow;
    logic        w_underflow;
    logic        w_inexact;

    // Upper product bits can never be set by a 24x24 multiply
    logic        w_unused;
    assign w_unused = ^prod[63:48];

    // Handshake enables: a stage may load when it is empty or its successor moves
    assign w_en2    = !r_s2_valid | out_ready;
    assign w_en1    = !r_s1_valid | w_en2;
    assign in_ready = w_en1 & reset;

    // Normalize: product of two [1,2) significands lies in [1,4)
    assign w_hi     = prod[47];
    assign w_mant   = w_hi ? prod[46:24] : prod[45:23];
    assign w_guard  = w_hi ? prod[23] : prod[22];
    assign w_sticky = w_hi ? (|prod[22:0]) : (|prod[21:0]);
    assign w_exp    = exp_sum + {9'd0, w_hi};

    // Round to nearest-even; a carry out of the mantissa bumps the exponent
    assign w_inc      = r_s1_guard & (r_s1_sticky | r_s1_mant[0]);
    assign w_mant_sum = {1'b0, r_s1_mant} + {23'd0, w_inc};
    assign w_mant_r   = w_mant_sum[22:0];
    assign w_exp_r    = r_s1_exp + {9'd0, w_mant_sum[23]};

    // Classify and pack; special classes override any numeric outcome
    always_comb begin
        w_result    = {r_s1_sign, w_exp_r[7:0], w_mant_r};
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_inexact   = r_s1_guard | r_s1_sticky;
        if (r_s1_nan) begin
            w_result  = 32'h7FC0_0000;
            w_inexact = 1'b0;
        end else if (r_s1_inf) begin
            w_result  = {r_s1_sign, 8'hFF, 23'd0};
            w_inexact = 1'b0;
        end else if (r_s1_zero) begin
            w_result  = {r_s1_sign, 31'd0};
            w_inexact = 1'b0;
        end else if ($signed(w_exp_r) >= 10'sd255) begin
            w_result   = {r_s1_sign, 8'hFF, 23'd0};
            w_overflow = 1'b1;
            w_inexact  = 1'b1;
        end else if ($signed(r_s1_exp) <= 10'sd0) begin
            // No denormal output: anything below the normal range flushes to zero
            w_result    = {r_s1_sign, 31'd0};
            w_underflow = 1'b1;
            w_inexact   = 1'b1;
        end
    end

    // Stage 1 register: capture normalized operand on input accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_mant   <= 23'd0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_exp    <= 10'd0;
            r_s1_sign   <= 1'b0;
            r_s1_nan    <= 1'b0;
            r_s1_inf    <= 1'b0;
            r_s1_zero   <= 1'b0;
        end else if (w_en1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mant   <= w_mant;
                r_s1_guard  <= w_guard;
                r_s1_sticky <= w_sticky;
                r_s1_exp    <= w_exp;
                r_s1_sign   <= sign;
                r_s1_nan    <= is_nan;
                r_s1_inf    <= is_inf;
                r_s1_zero   <= is_zero;
            end
        end
    end

    // Stage 2 register: rounded/packed result, held stable while downstream stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid  <= 1'b0;
            r_result    <= 32'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (w_en2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result    <= w_result;
                r_overflow  <= w_overflow;
                r_underflow <= w_underflow;
                r_inexact   <= w_inexact;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_fmul_round.sv
// tb/tb_fmul_round.sv - directed self-checking bench for fmul_round
module tb_fmul_round;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] prod;
    logic        sign;
    logic [9:0]  exp_sum;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_total;
    int n_bad;
    int sent;
    int got;
    int stall;
    bit stall_done;

    logic [9:0]  e_tab [4];
    logic [31:0] r_tab [4];

    fmul_round u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .sign      (sign),
        .exp_sum   (exp_sum),
        .is_nan    (is_nan),
        .is_inf    (is_inf),
        .is_zero   (is_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp_v);
        end
    endtask

    // One isolated operation: accept, confirm 2-cycle latency, check result and {ov,uf,inx}
    task automatic run_one(input string tag, input logic [63:0] p, input logic s,
                           input logic [9:0] e, input logic n, input logic i, input logic z,
                           input logic [31:0] er, input logic [2:0] ef);
        prod = p; sign = s; exp_sum = e; is_nan = n; is_inf = i; is_zero = z;
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_v1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_v2"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, result, er);
        check({tag, "_flg"}, {29'd0, overflow, underflow, inexact}, {29'd0, ef});
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        prod = 64'd0; sign = 1'b0; exp_sum = 10'd0;
        is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
        e_tab = '{10'd100, 10'd101, 10'd102, 10'd103};
        r_tab = '{32'h3200_0000, 32'h3280_0000, 32'h3300_0000, 32'h3380_0000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_irdy", {31'd0, in_ready}, 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_flg", {29'd0, overflow, underflow, inexact}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_irdy", {31'd0, in_ready}, 32'd1);

        // Directed numeric vectors
        run_one("m15x15", 64'h0000_9000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000);
        run_one("m1x1",   64'h0000_4000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b000);
        run_one("tie_up", 64'h0000_6000_00C0_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 32'h3FC0_0002, 3'b001);
        run_one("tie_dn", 64'h0000_4000_0040_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001);
        run_one("rcarry", 64'h0000_FFFF_FF80_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 32'h4080_0000, 3'b001);
        run_one("ovf",    64'h0000_8000_0000_0000, 1'b1, 10'd254, 1'b0, 1'b0, 1'b0, 32'hFF80_0000, 3'b101);
        run_one("ovf_rc", 64'h0000_FFFF_FF80_0000, 1'b0, 10'd253, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101);
        run_one("unf",    64'h0000_4000_0000_0000, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b011);
        run_one("unf_ng", 64'h0000_4000_0000_0000, 1'b1, 10'h3FB, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011);
        run_one("minnorm",64'h0000_4000_0000_0000, 1'b0, 10'd1,   1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000);
        run_one("nan",    64'h0000_8000_0000_0000, 1'b1, 10'd254, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b000);
        run_one("inf",    64'h0000_4000_0000_0000, 1'b1, 10'd0,   1'b0, 1'b1, 1'b1, 32'hFF80_0000, 3'b000);
        run_one("zero",   64'h0000_9000_0000_0000, 1'b1, 10'd127, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b000);

        // Back-to-back with 3 cycles of backpressure once the first result is valid
        @(posedge clk); #1;
        sent = 0; got = 0; stall = 0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (sent < 4) begin
                in_valid = 1'b1; prod = 64'h0000_4000_0000_0000; sign = 1'b0;
                exp_sum = e_tab[sent]; is_nan = 1'b0; is_inf = 1'b0; is_zero = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && !stall_done) begin
                stall = 3;
                stall_done = 1'b1;
            end
            out_ready = (stall == 0);
            @(negedge clk);
            if (stall > 0) begin
                check("bp_full_rdy", {31'd0, in_ready}, 32'd0);
                check("bp_hold_v", {31'd0, out_valid}, 32'd1);
                check("bp_hold_res", result, r_tab[got]);
            end
            if (out_valid && out_ready) begin
                check("bp_res", result, r_tab[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            if (stall > 0) stall--;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_got", got, 32'd4);
        check("bp_sent", sent, 32'd4);
        check("bp_stalled", {31'd0, stall_done}, 32'd1);
        @(negedge clk);
        check("bp_nodup", {31'd0, out_valid}, 32'd0);

        // Reset with two operations in flight
        @(posedge clk); #1;
        in_valid = 1'b1; prod = 64'h0000_4000_0000_0000; exp_sum = 10'd127;
        @(posedge clk); #1;
        exp_sum = 10'd128;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("inflt_v", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check("mrst_ovalid", {31'd0, out_valid}, 32'd0);
        check("mrst_irdy", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("mrst_rel_rdy", {31'd0, in_ready}, 32'd1);
        check("mrst_flush", {31'd0, out_valid}, 32'd0);
        run_one("post_rst", 64'h0000_9000_0000_0000, 1'b0, 10'd127, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
